// File: rtl/candy_pkg.sv
// Shared definitions for the candy refill draw logic: color width, default
// color count / retry limit, FSM state encoding and a modular increment helper.
package candy_pkg;

  localparam int COLOR_W        = 3;
  localparam int COUNT_W        = 4;
  localparam int TRIES_W        = 4;
  localparam int RND_W          = 13;
  localparam int NUM_COLORS_DEF = 6;
  localparam int MAX_TRIES_DEF  = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DRAW = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // (c + 1) mod n, with c assumed already below n.
  function automatic logic [COLOR_W-1:0] inc_mod(input logic [COLOR_W-1:0] c,
                                                 input int unsigned n);
    logic [COLOR_W-1:0] r;
    if ((32'(c) + 32'd1) >= n) begin
      r = '0;
    end else begin
      r = c + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/candy_accept.sv
// Combinational legality check for a drawn candidate color and computation of
// the fallback color used after too many rejections.
// Optional feature macro: NO_TRIPLE_EN (blocks a third identical color in a row).
module candy_accept
  import candy_pkg::*;
#(
  parameter int NUM_COLORS = NUM_COLORS_DEF
) (
  input  logic [COLOR_W-1:0] cand_i,
  input  logic [COLOR_W-1:0] hist0_i,     // most recent accepted color
  input  logic [COLOR_W-1:0] hist1_i,     // accepted color before that
  input  logic [1:0]         fill_i,      // number of valid history entries (0..2)
  output logic               accept_o,
  output logic [COLOR_W-1:0] fallback_o
);

  localparam int unsigned NC = NUM_COLORS;

  logic               in_range_s;
  logic               blocked_s;
  logic [COLOR_W-1:0] fb_base_s;

  assign in_range_s = (32'(cand_i) < NC);

  // Fallback follows the last accepted color; first tile of a run falls back to 0.
  always_comb begin
    fb_base_s = '0;
    if (fill_i == 2'd0) begin
      fb_base_s = '0;
    end else begin
      fb_base_s = inc_mod(hist0_i, NC);
    end
  end

`ifdef NO_TRIPLE_EN
  logic hist_full_s;
  assign hist_full_s = (fill_i == 2'd2);

  // Reject a candidate (or bump the fallback) that would repeat a color three times.
  always_comb begin
    blocked_s  = 1'b0;
    fallback_o = fb_base_s;
    if (hist_full_s && (cand_i == hist0_i) && (cand_i == hist1_i)) begin
      blocked_s = 1'b1;
    end else begin
      blocked_s = 1'b0;
    end
    if (hist_full_s && (fb_base_s == hist0_i) && (fb_base_s == hist1_i)) begin
      fallback_o = inc_mod(fb_base_s, NC);
    end else begin
      fallback_o = fb_base_s;
    end
  end
`else
  // Without the triple block the older history entry plays no role.
  logic unused_hist1_s;
  assign unused_hist1_s = ^hist1_i;
  assign blocked_s      = 1'b0;
  assign fallback_o     = fb_base_s;
`endif

  assign accept_o = in_range_s && !blocked_s;

endmodule

// File: rtl/candy_draw.sv
// Candy refill color drawer: for each tile of a run, draws random candidates,
// rejects illegal ones, forces a fallback after MAX_TRIES rejections and hands
// the color to the consumer with a valid/ready handshake.
// Optional feature macro: NO_TRIPLE_EN (see candy_accept).
module candy_draw
  import candy_pkg::*;
#(
  parameter int NUM_COLORS = NUM_COLORS_DEF,
  parameter int MAX_TRIES  = MAX_TRIES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] count,
  input  logic [RND_W-1:0]   rnd,
  output logic               rnd_en,
  output logic [COLOR_W-1:0] color,
  output logic               color_valid,
  input  logic               color_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [TRIES_W-1:0] MAX_T = TRIES_W'(MAX_TRIES);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [COLOR_W-1:0] hist0_q, hist0_d;
  logic [COLOR_W-1:0] hist1_q, hist1_d;
  logic [1:0]         fill_q, fill_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               done_d;
  logic               done_q;
  logic               valid_q;
  logic               rnd_en_q;
  logic               busy_q;

  logic [COLOR_W-1:0] cand_s;
  logic               accept_s;
  logic [COLOR_W-1:0] fallback_s;
  logic               take_s;
  logic [COLOR_W-1:0] take_color_s;
  logic               unused_rnd_s;

  assign cand_s       = rnd[COLOR_W-1:0];
  assign unused_rnd_s = ^rnd[RND_W-1:COLOR_W];

  candy_accept #(
    .NUM_COLORS (NUM_COLORS)
  ) u_accept (
    .cand_i     (cand_s),
    .hist0_i    (hist0_q),
    .hist1_i    (hist1_q),
    .fill_i     (fill_q),
    .accept_o   (accept_s),
    .fallback_o (fallback_s)
  );

  // Next-state logic: run start, candidate draw/retry/fallback, handshake and run end.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    tries_d      = tries_q;
    hist0_d      = hist0_q;
    hist1_d      = hist1_q;
    fill_d       = fill_q;
    color_d      = color_q;
    done_d       = 1'b0;
    take_s       = 1'b0;
    take_color_s = cand_s;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != 4'd0) begin
            state_d     = ST_DRAW;
            remaining_d = count;
            tries_d     = 4'd0;
            hist0_d     = 3'd0;
            hist1_d     = 3'd0;
            fill_d      = 2'd0;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DRAW: begin
        if (tries_q >= MAX_T) begin
          take_s       = 1'b1;
          take_color_s = fallback_s;
        end else if (accept_s) begin
          take_s       = 1'b1;
          take_color_s = cand_s;
        end else begin
          tries_d = tries_q + 4'd1;
        end

        if (take_s) begin
          color_d = take_color_s;
          state_d = ST_HOLD;
          tries_d = 4'd0;
          hist1_d = hist0_q;
          hist0_d = take_color_s;
          fill_d  = (fill_q == 2'd2) ? 2'd2 : (fill_q + 2'd1);
        end else begin
          state_d = ST_DRAW;
        end
      end

      ST_HOLD: begin
        if (color_ready) begin
          remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAW;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= 4'd0;
      tries_q     <= 4'd0;
      hist0_q     <= 3'd0;
      hist1_q     <= 3'd0;
      fill_q      <= 2'd0;
      color_q     <= 3'd0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      rnd_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      tries_q     <= tries_d;
      hist0_q     <= hist0_d;
      hist1_q     <= hist1_d;
      fill_q      <= fill_d;
      color_q     <= color_d;
      done_q      <= done_d;
      valid_q     <= (state_d == ST_HOLD);
      rnd_en_q    <= (state_d == ST_DRAW);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign color       = color_q;
  assign color_valid = valid_q;
  assign rnd_en      = rnd_en_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_candy_draw.sv
// Directed, table-driven bench for candy_draw with default parameters
// (NUM_COLORS=6, MAX_TRIES=7). Models the random generator: the presented
// word advances one step after every cycle in which rnd_en was high.
module tb_candy_draw;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  count;
  logic [12:0] rnd;
  logic        rnd_en;
  logic [2:0]  color;
  logic        color_valid;
  logic        color_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  candy_draw dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .count       (count),
    .rnd         (rnd),
    .rnd_en      (rnd_en),
    .color       (color),
    .color_valid (color_valid),
    .color_ready (color_ready),
    .busy        (busy),
    .done        (done)
  );

  int errors = 0;
  int checks = 0;

  logic [2:0] seq [16];
  int got [16];
  int n_xfer, n_rnd, first_lat, done_c, last_xfer_c;
  int stable_err, hold_rnd_err, timed_out;

  typedef struct {
    logic [2:0] s0;
    logic [2:0] s1;
    logic [2:0] s2;
    int         exp_color;
    int         exp_rnd;
    int         exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_seq(input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic [2:0] d,
                         input logic [2:0] pad);
    for (int i = 0; i < 16; i++) seq[i] = pad;
    seq[0] = a; seq[1] = b; seq[2] = c; seq[3] = d;
  endtask

  // One run: start at cycle 0, then per-cycle sampling on the falling edge.
  // hold_low: cycles color_ready stays low in each HOLD; abort_c: cycle at which
  // reset is pulsed; restart_c: cycle at which a (to-be-ignored) start is pulsed.
  task automatic run(input logic [3:0] cnt, input int hold_low,
                     input int abort_c, input int restart_c);
    int  idx;
    bit  prev_en;
    int  hold_cnt;
    bit  held_v;
    int  held_color;
    n_xfer = 0; n_rnd = 0; first_lat = -1; done_c = -1; last_xfer_c = -1;
    stable_err = 0; hold_rnd_err = 0; timed_out = 1;
    idx = 0; prev_en = 1'b0; hold_cnt = 0; held_v = 1'b0; held_color = 0;
    for (int i = 0; i < 16; i++) got[i] = -1;
    @(negedge clk);
    start       = 1'b1;
    count       = cnt;
    rnd         = {10'd0, seq[0]};
    color_ready = (hold_low == 0);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == abort_c) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        timed_out = 0;
        return;
      end
      if (c == restart_c) begin
        start = 1'b1;
        count = 4'd5;
      end
      if (prev_en && idx < 15) idx++;
      rnd     = {10'd0, seq[idx]};
      prev_en = rnd_en;
      if (rnd_en) n_rnd++;
      if (color_valid) begin
        if (first_lat < 0) first_lat = c;
        if (rnd_en) hold_rnd_err++;
        if (held_v && (int'(color) != held_color)) stable_err++;
        held_v      = 1'b1;
        held_color  = int'(color);
        color_ready = (hold_cnt >= hold_low);
        hold_cnt++;
        if (color_ready) begin
          if (n_xfer < 16) got[n_xfer] = int'(color);
          n_xfer++;
          last_xfer_c = c;
          held_v   = 1'b0;
          hold_cnt = 0;
        end
      end else begin
        color_ready = (hold_low == 0);
      end
      if (done) begin
        done_c    = c;
        timed_out = 0;
        return;
      end
    end
  endtask

  initial begin
    vecs[0] = '{3'd4, 3'd7, 3'd7, 4, 1, 2};
    vecs[1] = '{3'd0, 3'd7, 3'd7, 0, 1, 2};
    vecs[2] = '{3'd5, 3'd7, 3'd7, 5, 1, 2};
    vecs[3] = '{3'd6, 3'd7, 3'd2, 2, 3, 4};
    vecs[4] = '{3'd7, 3'd1, 3'd3, 1, 2, 3};
    vecs[5] = '{3'd6, 3'd6, 3'd6, 0, 8, 9};
    vecs[6] = '{3'd3, 3'd7, 3'd7, 3, 1, 2};

    reset = 1'b1; start = 1'b0; count = 4'd0; rnd = 13'd0; color_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(color_valid), 0);
    check("reset_rnd_en", int'(rnd_en), 0);
    check("reset_done", int'(done), 0);
    check("reset_color", int'(color), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single-tile runs with ready tied high.
    for (int v = 0; v < 7; v++) begin
      set_seq(vecs[v].s0, vecs[v].s1, vecs[v].s2, 3'd7, 3'd7);
      run(4'd1, 0, -1, -1);
      check($sformatf("v%0d_timeout", v), timed_out, 0);
      check($sformatf("v%0d_color", v), got[0], vecs[v].exp_color);
      check($sformatf("v%0d_xfers", v), n_xfer, 1);
      check($sformatf("v%0d_rnd_cycles", v), n_rnd, vecs[v].exp_rnd);
      check($sformatf("v%0d_latency", v), first_lat, vecs[v].exp_lat);
      check($sformatf("v%0d_done_delay", v), done_c - last_xfer_c, 1);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), int'(done), 0);
    end

    // Fallback on every tile: all candidates illegal.
    set_seq(3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
    run(4'd2, 0, -1, -1);
    check("fb_timeout", timed_out, 0);
    check("fb_xfers", n_xfer, 2);
    check("fb_color0", got[0], 0);
    check("fb_color1", got[1], 1);
    check("fb_rnd_cycles", n_rnd, 16);
    check("fb_done_cycle", done_c, 19);

    // Throughput: one tile per two cycles.
    set_seq(3'd1, 3'd2, 3'd3, 3'd7, 3'd7);
    run(4'd3, 0, -1, -1);
    check("tp_colors", got[0] * 100 + got[1] * 10 + got[2], 123);
    check("tp_latency", first_lat, 2);
    check("tp_done_cycle", done_c, 7);

    // Back-pressure for 5 cycles, with a start pulse while busy.
    set_seq(3'd3, 3'd7, 3'd7, 3'd7, 3'd7);
    run(4'd1, 5, -1, 4);
    check("bp_timeout", timed_out, 0);
    check("bp_xfers", n_xfer, 1);
    check("bp_color", got[0], 3);
    check("bp_stable", stable_err, 0);
    check("bp_rnd_en_in_hold", hold_rnd_err, 0);
    check("bp_done_cycle", done_c, 8);
    @(negedge clk);
    check("bp_restart_ignored", int'(busy), 0);

    // Triple repetition behaviour.
    set_seq(3'd3, 3'd3, 3'd3, 3'd1, 3'd7);
    run(4'd3, 0, -1, -1);
    check("tr_xfers", n_xfer, 3);
`ifdef NO_TRIPLE_EN
    check("tr_colors", got[0] * 100 + got[1] * 10 + got[2], 331);
    check("tr_rnd_cycles", n_rnd, 4);
`else
    check("tr_colors", got[0] * 100 + got[1] * 10 + got[2], 333);
    check("tr_rnd_cycles", n_rnd, 3);
`endif

    // Reset in DRAW after one transfer, then a zero-length run.
    set_seq(3'd2, 3'd7, 3'd7, 3'd7, 3'd7);
    run(4'd2, 0, 6, -1);
    check("ab_xfers", n_xfer, 1);
    check("ab_color_before", got[0], 2);
    check("ab_busy", int'(busy), 0);
    check("ab_valid", int'(color_valid), 0);
    check("ab_rnd_en", int'(rnd_en), 0);
    check("ab_color", int'(color), 0);
    begin
      int dcount = int'(done);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (done) dcount++;
      end
      check("ab_no_done", dcount, 0);
    end
    run(4'd0, 0, -1, -1);
    check("z_done_cycle", done_c, 1);
    check("z_busy", int'(busy), 0);
    check("z_valid", int'(color_valid), 0);
    check("z_rnd_en", int'(rnd_en), 0);
    check("z_color", int'(color), 0);
    @(negedge clk);
    check("z_done_pulse", int'(done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/candy_draw.md
CANDY_DRAW -- requirements
Module: candy_draw

Interface
REQ-001 Parameter NUM_COLORS, default 6, number of legal candy colors (2..8).
REQ-002 Parameter MAX_TRIES, default 7, consecutive rejections allowed before the fallback color is used (1..15).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle pulse requesting a refill run; ignored while busy=1.
REQ-006 count  in  4  number of tiles in the run, sampled with start.
REQ-007 rnd  in  13  pseudo-random word from the random generator; only rnd[2:0] is used.
REQ-008 rnd_en  out  1  advance request to the random generator; the next cycle presents a new word.
REQ-009 color  out  3  drawn candy color, held stable while color_valid=1.
REQ-010 color_valid  out  1  color is valid.
REQ-011 color_ready  in  1  consumer accepts color; transfer when color_valid and color_ready are both 1.
REQ-012 busy  out  1  run in progress (state other than IDLE).
REQ-013 done  out  1  one-cycle pulse after the last transfer of a run.

Function
REQ-014 States: IDLE, DRAW, HOLD; encoding is 2 bits.
REQ-015 IDLE: on start with count>0 -> DRAW, remaining=count, tries=0, history cleared; on start with count=0 -> stay IDLE, done=1 next cycle.
REQ-016 DRAW: rnd_en=1 every DRAW cycle; candidate = rnd[2:0].
REQ-017 Candidate accepted when candidate < NUM_COLORS and not blocked per REQ-026; accepted -> color registered, HOLD, color_valid=1 next cycle, tries=0.
REQ-018 Rejected candidate: tries+1, stay DRAW; when tries reaches MAX_TRIES, the next DRAW cycle forces the fallback color.
REQ-019 Fallback color = (last accepted color + 1) mod NUM_COLORS; 0 when no color has been accepted in the run.
REQ-020 HOLD: rnd_en=0; color and color_valid held until color_ready=1.
REQ-021 Transfer in HOLD: remaining-1; remaining becomes 0 -> IDLE, done=1 next cycle; otherwise -> DRAW.
REQ-022 Minimum latency: start at cycle T, first color_valid at T+2; one tile per 2 cycles with color_ready tied high and no rejections.
REQ-023 History: last two accepted colors in the run plus a 2-bit fill count, updated on acceptance.

Reset
REQ-024 On reset: state=IDLE; color=0, color_valid=0, rnd_en=0, busy=0, done=0; remaining, tries and history cleared.
REQ-025 Reset mid-run aborts the run with no done pulse; any held color is discarded.

Configuration
REQ-026 With NO_TRIPLE_EN defined: a candidate equal to both history entries (history full) is rejected and counted as a try, and a fallback is never equal to both history entries (if it would be, use fallback+1 mod NUM_COLORS).
REQ-027 Without NO_TRIPLE_EN: history affects only the fallback; three equal colors in a row are allowed.

Structure
REQ-028 Shared package candy_pkg holds COLOR_W=3, the default NUM_COLORS and the state typedef/encoding.
REQ-029 One sub-module, candy_accept: combinational legality check (range, triple block) returning accept and the fallback color.

Verification
REQ-030 count=1, rnd[2:0]=4, color_ready=1 -> color=4, color_valid at T+2, done at T+3.
REQ-031 rnd[2:0] sequence 6,7,2 (NUM_COLORS=6) -> exactly one transfer, color=2, two rejections, rnd_en high for 3 cycles.
REQ-032 rnd[2:0] held at 7, MAX_TRIES=7, count=2 -> colors 0 then 1 via fallback.
REQ-033 color_ready low for 5 cycles in HOLD -> color stable, rnd_en=0 throughout, single transfer on release.
REQ-034 NO_TRIPLE_EN, rnd[2:0] 3,3,3,1, count=3 -> colors 3,3,1; without the macro -> 3,3,3.
REQ-035 reset asserted in DRAW mid-run, then start with count=0 -> all outputs 0, no done pulse from the aborted run, done pulse 1 cycle after the new start.
